posit_accum_window_collector: RTL and testbench

// Sits directly downstream of the posit accumulate-and-round stage. That stage emits one rounded posit per input

---
 rtl/posit_accum_window_collector.sv | 109 ++++++++++
 tb/tb_posit_accum_window_collector.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accum_window_collector.sv
// Collects the final (eow) word of each sow..eow window from the posit accumulator, tags it with
// its element count and a NaR flag, and queues it in a first-word-fall-through FIFO.
module posit_accum_window_collector #(
    parameter int unsigned POSIT_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rts_i,
    input  logic                     sow_i,
    input  logic                     eow_i,
    input  logic [POSIT_WIDTH-1:0]   data_i,
    output logic                     rtr_o,
    output logic                     rts_o,
    output logic [POSIT_WIDTH-1:0]   data_o,
    output logic [CNT_WIDTH-1:0]     count_o,
    output logic                     nar_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     err_o,
    input  logic                     rtr_i
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StOpen = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_next;
    logic                   err_q, err_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;

    logic [POSIT_WIDTH-1:0] data_mem [DEPTH];
    logic [CNT_WIDTH-1:0]   cnt_mem  [DEPTH];
    logic                   nar_mem  [DEPTH];

    logic full, empty, xfer_in, xfer_out, framed, accept, push, nar_in;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign rtr_o    = ~full;
    assign rts_o    = ~empty;
    assign xfer_in  = rts_i & rtr_o;
    assign xfer_out = rts_o & rtr_i;

    // A word belongs to a window only if it opens one or arrives while one is open.
    assign framed   = sow_i | (state_q == StOpen);
    assign accept   = xfer_in & framed;
    assign push     = accept & eow_i;
    assign nar_in   = (data_i == {1'b1, {(POSIT_WIDTH-1){1'b0}}});

    assign cnt_next = sow_i ? CNT_WIDTH'(1) :
                      ((&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (accept) begin
            cnt_d   = cnt_next;
            state_d = eow_i ? StIdle : StOpen;
        end
        if (xfer_in & ~framed) err_d = 1'b1;
        if (xfer_in & sow_i & (state_q == StOpen)) err_d = 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (xfer_out) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push & ~xfer_out) level_d = level_q + LVL_W'(1);
        else if (~push & xfer_out) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= data_i;
            cnt_mem[wr_ptr_q]  <= cnt_next;
            nar_mem[wr_ptr_q]  <= nar_in;
        end
    end

    assign data_o  = empty ? '0 : data_mem[rd_ptr_q];
    assign count_o = empty ? '0 : cnt_mem[rd_ptr_q];
    assign nar_o   = empty ? 1'b0 : nar_mem[rd_ptr_q];
    assign level_o = level_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_posit_accum_window_collector.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle against a
// queue-based model of the window collector.
module tb_posit_accum_window_collector;
    localparam int DEPTH = 4;
    localparam int MAXC  = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rts_i, sow_i, eow_i, rtr_i;
    logic [7:0]  data_i;
    logic        rtr_o, rts_o, nar_o, err_o;
    logic [7:0]  data_o;
    logic [15:0] count_o;
    logic [2:0]  level_o;

    posit_accum_window_collector #(
        .POSIT_WIDTH(8),
        .CNT_WIDTH  (16),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rts_i   (rts_i),
        .sow_i   (sow_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .rtr_o   (rtr_o),
        .rts_o   (rts_o),
        .data_o  (data_o),
        .count_o (count_o),
        .nar_o   (nar_o),
        .level_o (level_o),
        .err_o   (err_o),
        .rtr_i   (rtr_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  d;
        logic [15:0] c;
        logic        n;
    } ent_t;

    ent_t mq[$];
    int   m_cnt;
    bit   m_open;
    bit   m_err;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt  = 0;
        m_open = 0;
        m_err  = 0;
    endtask

    task automatic check_all();
        chk("rts_o", {31'd0, rts_o}, (mq.size() != 0) ? 1 : 0);
        chk("rtr_o", {31'd0, rtr_o}, (mq.size() < DEPTH) ? 1 : 0);
        chk("level_o", {29'd0, level_o}, mq.size());
        chk("err_o", {31'd0, err_o}, {31'd0, m_err});
        if (mq.size() != 0) begin
            chk("data_o", {24'd0, data_o}, {24'd0, mq[0].d});
            chk("count_o", {16'd0, count_o}, {16'd0, mq[0].c});
            chk("nar_o", {31'd0, nar_o}, {31'd0, mq[0].n});
        end else begin
            chk("data_o_empty", {24'd0, data_o}, 0);
            chk("count_o_empty", {16'd0, count_o}, 0);
            chk("nar_o_empty", {31'd0, nar_o}, 0);
        end
    endtask

    // One clock: decide transfers from pre-edge state, advance the model at the edge, check at negedge.
    task automatic cycle(output bit did_in);
        bit   xin, xout;
        int   nc;
        ent_t e;
        xin    = rts_i && (mq.size() < DEPTH);
        xout   = (mq.size() > 0) && rtr_i;
        did_in = xin;
        @(posedge clk);
        if (xout) void'(mq.pop_front());
        if (xin) begin
            if (!m_open && !sow_i) begin
                m_err = 1;
            end else begin
                if (m_open && sow_i) m_err = 1;
                nc    = sow_i ? 1 : ((m_cnt == MAXC) ? MAXC : m_cnt + 1);
                m_cnt = nc;
                if (eow_i) begin
                    e.d = data_i;
                    e.c = nc[15:0];
                    e.n = (data_i == 8'h80);
                    mq.push_back(e);
                    m_open = 0;
                end else begin
                    m_open = 1;
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input bit s, input bit e, input logic [7:0] d);
        bit got = 0;
        rts_i  = 1'b1;
        sow_i  = s;
        eow_i  = e;
        data_i = d;
        for (int i = 0; i < 50 && !got; i++) cycle(got);
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
    endtask

    task automatic drain();
        bit dummy;
        rts_i = 1'b0;
        rtr_i = 1'b1;
        for (int i = 0; i < 20 && mq.size() > 0; i++) cycle(dummy);
        chk("drain_level", {29'd0, level_o}, 0);
    endtask

    initial begin
        bit dummy;
        rst_n  = 1'b0;
        rts_i  = 1'b0;
        sow_i  = 1'b0;
        eow_i  = 1'b0;
        data_i = 8'h00;
        rtr_i  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rts_o", {31'd0, rts_o}, 0);
        chk("rst_rtr_o", {31'd0, rtr_o}, 1);
        chk("rst_level_o", {29'd0, level_o}, 0);
        chk("rst_data_o", {24'd0, data_o}, 0);
        chk("rst_count_o", {16'd0, count_o}, 0);
        chk("rst_err_o", {31'd0, err_o}, 0);
        rst_n = 1'b1;
        cycle(dummy);

        // Window of four words; only the eow word appears.
        rtr_i = 1'b0;
        send(1, 0, 8'h11);
        send(0, 0, 8'h22);
        send(0, 0, 8'h33);
        chk("t1_no_early_out", {31'd0, rts_o}, 0);
        send(0, 1, 8'h40);
        chk("t1_data", {24'd0, data_o}, 32'h40);
        chk("t1_count", {16'd0, count_o}, 4);
        chk("t1_nar", {31'd0, nar_o}, 0);
        chk("t1_err", {31'd0, err_o}, 0);
        drain();

        // Single-element NaR window.
        rtr_i = 1'b0;
        chk("t2_rts_before", {31'd0, rts_o}, 0);
        send(1, 1, 8'h80);
        chk("t2_rts_after", {31'd0, rts_o}, 1);
        chk("t2_data", {24'd0, data_o}, 32'h80);
        chk("t2_count", {16'd0, count_o}, 1);
        chk("t2_nar", {31'd0, nar_o}, 1);
        drain();

        // Fill the FIFO, hold a fifth eow, then release.
        rtr_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            send(1, 0, 8'h01);
            send(0, 1, 8'h10 + 8'(w));
        end
        rts_i  = 1'b1;
        sow_i  = 1'b1;
        eow_i  = 1'b1;
        data_i = 8'h55;
        cycle(dummy);
        cycle(dummy);
        chk("t3_level_full", {29'd0, level_o}, 4);
        chk("t3_rtr_full", {31'd0, rtr_o}, 0);
        chk("t3_head_first", {24'd0, data_o}, 32'h10);
        rtr_i = 1'b1;
        cycle(dummy);
        chk("t4_pop_only", {29'd0, level_o}, 3);
        chk("t4_rtr_rises", {31'd0, rtr_o}, 1);
        cycle(dummy);
        chk("t4_push_pop_const", {29'd0, level_o}, 3);
        chk("t4_head_third", {24'd0, data_o}, 32'h12);
        drain();

        // Framing errors: orphan word while idle, then sow inside an open window.
        send(0, 0, 8'h77);
        chk("t5_err_a", {31'd0, err_o}, 1);
        chk("t5_no_push", {29'd0, level_o}, 0);
        rtr_i = 1'b0;
        send(1, 0, 8'h01);
        send(0, 0, 8'h02);
        send(1, 0, 8'h03);
        send(0, 0, 8'h04);
        send(0, 1, 8'h48);
        chk("t5_level", {29'd0, level_o}, 1);
        chk("t5_count", {16'd0, count_o}, 3);
        chk("t5_err_sticky", {31'd0, err_o}, 1);
        drain();

        // Asynchronous reset with results buffered and a window open.
        rtr_i = 1'b0;
        send(1, 1, 8'h21);
        send(1, 1, 8'h22);
        send(1, 0, 8'h23);
        chk("t6_level_pre", {29'd0, level_o}, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rts_o", {31'd0, rts_o}, 0);
        chk("t6_level_o", {29'd0, level_o}, 0);
        chk("t6_rtr_o", {31'd0, rtr_o}, 1);
        chk("t6_err_o", {31'd0, err_o}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 0, 8'h31);
        send(0, 0, 8'h32);
        send(0, 1, 8'h50);
        chk("t6_count_fresh", {16'd0, count_o}, 3);
        chk("t6_data_fresh", {24'd0, data_o}, 32'h50);
        drain();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rts_i  = ($urandom_range(0, 9) < 7);
            sow_i  = ($urandom_range(0, 9) < 3);
            eow_i  = ($urandom_range(0, 99) < 35);
            data_i = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            rtr_i  = ($urandom_range(0, 9) < 6);
            cycle(dummy);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
